ps2_rx_filtered: RTL and testbench
==================================

// Module: ps2_rx_filtered
// PURPOSE
//  Parametrised PS/2-style serial receiver. Runs on the system clock and oversamples SCL/SDA.
//  Adds synchronisers, glitch filtering, configurable data width and parity mode, stop-bit check,
//  inter-edge timeout and a valid/ready output register with overrun detection.
//  Sits between the PS/2 pins and the keyboard/command decoder.
// PARAMETERS
//  DP_size      8       data bits per frame (1..16), LSB first
//  PARITY_MODE  1       0 = no parity bit, 1 = odd parity, 2 = even parity
//  FILTER_LEN   4       filter cycles a synced input must hold a new level before it is accepted (>=1)
//  TIMEOUT_CYC  100000  clock cycles without an SCL falling edge mid-frame before abort (>=2)
// PORTS
//  CLOCK        in   1        system clock, all logic on rising edge
//  RESET        in   1        synchronous, active-high reset
//  SCL          in   1        PS/2 clock pin, asynchronous, idles high
//  SDA          in   1        PS/2 data pin, asynchronous, idles high
//  RX_READY     in   1        consumer accepts RX_DATA when RX_READY & DATA_VALID
//  RX_DATA      out  DP_size  last committed data word; held while DATA_VALID=1
//  DATA_VALID   out  1        RX_DATA holds an unconsumed word
//  PARITY_ERR   out  1        1-cycle pulse: parity mismatch, frame dropped
//  FRAME_ERR    out  1        1-cycle pulse: stop bit sampled 0, frame dropped
//  TIMEOUT_ERR  out  1        1-cycle pulse: mid-frame timeout, frame dropped
//  OVERRUN      out  1        1-cycle pulse: good frame lost because the output register was full
//  BUSY         out  1        receiver FSM is not in IDLE
// BEHAVIOUR
//  Reset: all outputs 0; FSM IDLE; synchronisers and filters preset to 1 so no edge is seen after reset.
//  Input path: 2-FF synchroniser per pin, then filter. The filtered level changes only after the synced
//   level differs from it for FILTER_LEN consecutive cycles. Shorter glitches are ignored.
//  scl_fall = filtered SCL 1->0, one cycle wide. On that cycle SDA is sampled as the filtered SDA value.
//  FSM (advances only on scl_fall, except timeout):
//   IDLE:   SDA=0 -> DATA, bit_cnt=0, parity accumulator cleared. SDA=1 -> stay IDLE, no error.
//   DATA:   shift[bit_cnt]<=SDA, bit_cnt++. After bit DP_size-1 -> PARITY if PARITY_MODE!=0, else STOP.
//   PARITY: capture parity bit -> STOP.
//   STOP:   check the frame -> IDLE.
//            ok = SDA==1 and (PARITY_MODE==0 or parity matches).
//            Odd mode: data plus parity bit hold an odd count of ones. Even mode: an even count.
//            On a bad frame, PARITY_ERR and FRAME_ERR may pulse together. Nothing is committed.
//  Timeout: in any non-IDLE state a counter increments each cycle and clears on scl_fall.
//   On reaching TIMEOUT_CYC-1: TIMEOUT_ERR pulses, FSM -> IDLE, partial data discarded.
//   Timeout takes priority over a coincident scl_fall.
//  Commit, in the cycle after the STOP scl_fall:
//   - If DATA_VALID=0, or RX_READY=1 in the commit cycle: load RX_DATA and set DATA_VALID=1.
//   - Otherwise RX_DATA is unchanged, the new word is dropped and OVERRUN pulses.
//   DATA_VALID clears when RX_READY & DATA_VALID and there is no same-cycle commit.
//   Error and OVERRUN pulses align with the cycle in which DATA_VALID would rise.
//  Latency: raw pin edge -> filtered edge = 2+FILTER_LEN cycles. Stop-bit scl_fall -> DATA_VALID = 1 cycle.
//  BUSY = (state != IDLE). It drops the cycle after the STOP scl_fall or the timeout.
//  RESET mid-frame discards the partial frame and clears DATA_VALID and RX_DATA.
//  Width rules: bit_cnt uses $clog2(DP_size+1) bits. The timeout counter uses $clog2(TIMEOUT_CYC) bits and saturates.
// TESTING
//  1 RESET for 3 cycles with SCL=SDA=1 -> all outputs 0, BUSY=0, no pulses for 100 cycles after release.
//  2 Frame 0xA5, odd parity bit 1, stop 1, RX_READY=0
//     -> DATA_VALID=1, RX_DATA=0xA5, no error pulses.
//     Then an RX_READY pulse -> DATA_VALID=0 next cycle.
//  3 Frame 0x3C with parity bit 0 (odd mode) -> PARITY_ERR 1-cycle pulse, DATA_VALID stays 0.
//     Same frame with stop bit 0 and correct parity -> FRAME_ERR only.
//  4 SCL stops after 4 data bits -> TIMEOUT_ERR exactly TIMEOUT_CYC cycles after the last scl_fall, BUSY=0.
//     Next full frame 0x12 -> DATA_VALID=1, RX_DATA=0x12.
//  5 Frames 0x11 then 0x22 back-to-back with RX_READY=0
//     -> RX_DATA=0x11 held, OVERRUN pulses once on the second frame.
//     Repeat with RX_READY=1 in the commit cycle -> RX_DATA=0x22, no OVERRUN.
//  6 SCL low glitches of FILTER_LEN-1 cycles inside a 0x5A frame -> RX_DATA=0x5A, no errors.
//     RESET asserted mid-frame -> BUSY=0, no commit.

Source files
------------

// File: rtl/ps2_rx_filtered.sv
// ps2_rx_filtered: oversampled PS/2 receiver with glitch filters, parity/stop check, timeout and valid/ready output
module ps2_rx_filtered #(
    parameter int DP_size     = 8,
    parameter int PARITY_MODE = 1,
    parameter int FILTER_LEN  = 4,
    parameter int TIMEOUT_CYC = 100000
) (
    input  logic               CLOCK,
    input  logic               RESET,
    input  logic               SCL,
    input  logic               SDA,
    input  logic               RX_READY,
    output logic [DP_size-1:0] RX_DATA,
    output logic               DATA_VALID,
    output logic               PARITY_ERR,
    output logic               FRAME_ERR,
    output logic               TIMEOUT_ERR,
    output logic               OVERRUN,
    output logic               BUSY
);
    localparam int FW = FILTER_LEN > 1 ? $clog2(FILTER_LEN) : 1;
    localparam int BW = $clog2(DP_size + 1);
    localparam int TW = $clog2(TIMEOUT_CYC);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;
    state_t state, state_nx;

    logic [1:0]         sync1, sync2, filt;
    logic               scl_prev, scl_fall, sda_bit, timeout, frame_done, par_ok, frame_ok, commit;
    logic               par_acc;
    logic [BW-1:0]      bit_cnt;
    logic [TW-1:0]      to_cnt;
    logic [DP_size-1:0] shift;

    always_ff @(posedge CLOCK)
        if (RESET) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {SDA, SCL};
            sync2 <= sync1;
        end

    // bit 0 = SCL, bit 1 = SDA; a level is accepted only after FILTER_LEN consecutive differing samples
    for (genvar i = 0; i < 2; i++) begin : g_filt
        logic [FW-1:0] cnt;
        logic          lvl;
        always_ff @(posedge CLOCK)
            if (RESET) begin
                cnt <= '0;
                lvl <= 1'b1;
            end else if (sync2[i] == lvl) begin
                cnt <= '0;
            end else if (cnt == FW'(FILTER_LEN - 1)) begin
                lvl <= sync2[i];
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        assign filt[i] = lvl;
    end

    always_comb begin
        scl_fall   = scl_prev & ~filt[0];
        sda_bit    = filt[1];
        timeout    = (state != IDLE) && (to_cnt == TW'(TIMEOUT_CYC - 1));
        frame_done = scl_fall && (state == STOP) && !timeout;
        par_ok     = PARITY_MODE == 0 ? 1'b1 : (PARITY_MODE == 1 ? par_acc : ~par_acc);
        frame_ok   = sda_bit && par_ok;
        commit     = frame_done && frame_ok && (!DATA_VALID || RX_READY);
    end

    always_ff @(posedge CLOCK)
        if (RESET) state <= IDLE;
        else       state <= state_nx;

    always_comb begin
        state_nx = state;
        if (timeout)
            state_nx = IDLE;
        else if (scl_fall)
            case (state)
                IDLE:    state_nx = sda_bit ? IDLE : DATA;
                DATA:    state_nx = bit_cnt == BW'(DP_size - 1) ? (PARITY_MODE != 0 ? PARITY : STOP) : DATA;
                PARITY:  state_nx = STOP;
                default: state_nx = IDLE;
            endcase
    end

    always_comb begin
        BUSY        = state != IDLE;
        TIMEOUT_ERR = timeout;
    end

    // par_acc folds in every data bit and the parity bit, so odd parity is satisfied when it ends at 1
    always_ff @(posedge CLOCK)
        if (RESET) begin
            scl_prev <= 1'b1;
            to_cnt   <= '0;
            bit_cnt  <= '0;
            par_acc  <= 1'b0;
            shift    <= '0;
        end else begin
            scl_prev <= filt[0];
            to_cnt   <= (state == IDLE || scl_fall) ? '0 : (to_cnt == '1 ? to_cnt : to_cnt + 1'b1);
            if (scl_fall)
                case (state)
                    IDLE: begin
                        bit_cnt <= '0;
                        par_acc <= 1'b0;
                        shift   <= '0;
                    end
                    DATA: begin
                        shift   <= shift | (DP_size'(sda_bit) << bit_cnt);
                        bit_cnt <= bit_cnt + 1'b1;
                        par_acc <= par_acc ^ sda_bit;
                    end
                    PARITY:  par_acc <= par_acc ^ sda_bit;
                    default: ;
                endcase
        end

    always_ff @(posedge CLOCK)
        if (RESET) begin
            RX_DATA    <= '0;
            DATA_VALID <= 1'b0;
            PARITY_ERR <= 1'b0;
            FRAME_ERR  <= 1'b0;
            OVERRUN    <= 1'b0;
        end else begin
            PARITY_ERR <= frame_done && !par_ok;
            FRAME_ERR  <= frame_done && !sda_bit;
            OVERRUN    <= frame_done && frame_ok && DATA_VALID && !RX_READY;
            if (commit) begin
                RX_DATA    <= shift;
                DATA_VALID <= 1'b1;
            end else if (RX_READY) begin
                DATA_VALID <= 1'b0;
            end
        end
endmodule

// File: tb/tb_ps2_rx_filtered.sv
// tb_ps2_rx_filtered: scenario tasks driving PS/2 frames, scoreboard queue of expected words
module tb_ps2_rx_filtered;
    localparam int F  = 4;
    localparam int TC = 200;
    localparam int H  = 10;

    logic       clk = 1'b0;
    logic       rst, scl, sda, rx_ready;
    logic [7:0] rx_data;
    logic       data_valid, parity_err, frame_err, timeout_err, overrun, busy;

    int tests = 0;
    int fails = 0;
    int n_par = 0, n_frm = 0, n_to = 0, n_ovr = 0;
    logic [7:0] exp_q[$];

    ps2_rx_filtered #(.DP_size(8), .PARITY_MODE(1), .FILTER_LEN(F), .TIMEOUT_CYC(TC)) dut (
        .CLOCK(clk), .RESET(rst), .SCL(scl), .SDA(sda), .RX_READY(rx_ready),
        .RX_DATA(rx_data), .DATA_VALID(data_valid), .PARITY_ERR(parity_err),
        .FRAME_ERR(frame_err), .TIMEOUT_ERR(timeout_err), .OVERRUN(overrun), .BUSY(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (parity_err)  n_par++;
        if (frame_err)   n_frm++;
        if (timeout_err) n_to++;
        if (overrun)     n_ovr++;
    end

    function automatic logic odd_p(input logic [7:0] d);
        return ~^d;
    endfunction

    task automatic waitn(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit glitch, input bit rdy_commit);
        sda = b;
        if (glitch) begin
            waitn(3);
            scl = 1'b0;
            waitn(F - 1);
            scl = 1'b1;
            waitn(H - 3 - (F - 1));
        end else begin
            waitn(H);
        end
        scl = 1'b0;
        if (rdy_commit) begin
            waitn(2 + F);
            rx_ready = 1'b1;
            waitn(1);
            rx_ready = 1'b0;
            waitn(H - 3 - F);
        end else begin
            waitn(H);
        end
        scl = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop, input bit glitch, input bit rdy_commit);
        send_bit(1'b0, glitch, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i], glitch, 1'b0);
        send_bit(pbit, glitch, 1'b0);
        send_bit(stop, glitch, rdy_commit);
        sda = 1'b1;
        waitn(5);
    endtask

    task automatic consume();
        rx_ready = 1'b1;
        waitn(1);
        rx_ready = 1'b0;
    endtask

    task automatic test_reset();
        int bad = 0;
        rst = 1'b1; scl = 1'b1; sda = 1'b1; rx_ready = 1'b0;
        waitn(3);
        rst = 1'b0;
        waitn(1);
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL reset_valid got=%b want=0", data_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL reset_data got=%h want=00", rx_data); end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b want=0", busy); end
        tests++; if ({parity_err, frame_err, timeout_err, overrun} !== 4'b0) begin
            fails++; $display("FAIL reset_pulses got=%b want=0000", {parity_err, frame_err, timeout_err, overrun});
        end
        for (int i = 0; i < 100; i++) begin
            waitn(1);
            if ({data_valid, busy, parity_err, frame_err, timeout_err, overrun} !== 6'b0) bad++;
        end
        tests++; if (bad !== 0) begin fails++; $display("FAIL reset_quiet got=%0d active cycles want=0", bad); end
    endtask

    task automatic test_valid_ready();
        int e0 = n_par + n_frm + n_to + n_ovr;
        logic [7:0] e;
        send_frame(8'hA5, odd_p(8'hA5), 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'hA5);
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL a5_valid got=%b want=1", data_valid); end
        e = exp_q.pop_front();
        tests++; if (rx_data !== e) begin fails++; $display("FAIL a5_data got=%h want=%h", rx_data, e); end
        tests++; if (n_par + n_frm + n_to + n_ovr - e0 !== 0) begin
            fails++; $display("FAIL a5_errors got=%0d want=0", n_par + n_frm + n_to + n_ovr - e0);
        end
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL a5_busy got=%b want=0", busy); end
        consume();
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL a5_consume got=%b want=0", data_valid); end
    endtask

    task automatic test_parity_frame();
        int p0 = n_par, f0 = n_frm;
        send_frame(8'h3C, ~odd_p(8'h3C), 1'b1, 1'b0, 1'b0);
        tests++; if (n_par - p0 !== 1) begin fails++; $display("FAIL par_err_pulse got=%0d want=1", n_par - p0); end
        tests++; if (n_frm - f0 !== 0) begin fails++; $display("FAIL par_no_frm got=%0d want=0", n_frm - f0); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL par_valid got=%b want=0", data_valid); end
        p0 = n_par; f0 = n_frm;
        send_frame(8'h3C, odd_p(8'h3C), 1'b0, 1'b0, 1'b0);
        tests++; if (n_frm - f0 !== 1) begin fails++; $display("FAIL frm_err_pulse got=%0d want=1", n_frm - f0); end
        tests++; if (n_par - p0 !== 0) begin fails++; $display("FAIL frm_no_par got=%0d want=0", n_par - p0); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL frm_valid got=%b want=0", data_valid); end
    endtask

    task automatic test_timeout();
        int t0 = n_to;
        int k = 0;
        logic seen = 1'b0;
        logic [7:0] e;
        send_bit(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0, 1'b0);
        sda = 1'b0;
        waitn(H);
        scl = 1'b0;
        while (!seen && k < 2 + F + TC + 50) begin
            waitn(1);
            k++;
            if (k == H) scl = 1'b1;
            seen = timeout_err;
        end
        tests++; if (!seen || k != 2 + F + TC) begin
            fails++; $display("FAIL timeout_latency got=%0d seen=%b want=%0d", k, seen, 2 + F + TC);
        end
        waitn(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL timeout_busy got=%b want=0", busy); end
        sda = 1'b1;
        waitn(5);
        tests++; if (n_to - t0 !== 1) begin fails++; $display("FAIL timeout_width got=%0d want=1", n_to - t0); end
        send_frame(8'h12, odd_p(8'h12), 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h12);
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL after_to_valid got=%b want=1", data_valid); end
        e = exp_q.pop_front();
        tests++; if (rx_data !== e) begin fails++; $display("FAIL after_to_data got=%h want=%h", rx_data, e); end
        consume();
    endtask

    task automatic test_back_to_back();
        int o0 = n_ovr;
        logic [7:0] e;
        send_frame(8'h11, odd_p(8'h11), 1'b1, 1'b0, 1'b0);
        exp_q.push_back(8'h11);
        send_frame(8'h22, odd_p(8'h22), 1'b1, 1'b0, 1'b0);
        tests++; if (n_ovr - o0 !== 1) begin fails++; $display("FAIL b2b_overrun got=%0d want=1", n_ovr - o0); end
        tests++; if (rx_data !== exp_q[0]) begin fails++; $display("FAIL b2b_held got=%h want=%h", rx_data, exp_q[0]); end
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL b2b_valid got=%b want=1", data_valid); end
        send_frame(8'h22, odd_p(8'h22), 1'b1, 1'b0, 1'b1);
        void'(exp_q.pop_front());
        exp_q.push_back(8'h22);
        tests++; if (n_ovr - o0 !== 1) begin fails++; $display("FAIL rdy_no_overrun got=%0d want=1", n_ovr - o0); end
        e = exp_q.pop_front();
        tests++; if (rx_data !== e) begin fails++; $display("FAIL rdy_data got=%h want=%h", rx_data, e); end
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL rdy_valid got=%b want=1", data_valid); end
        consume();
    endtask

    task automatic test_glitch();
        int e0 = n_par + n_frm + n_to + n_ovr;
        logic [7:0] e;
        send_frame(8'h5A, odd_p(8'h5A), 1'b1, 1'b1, 1'b0);
        exp_q.push_back(8'h5A);
        tests++; if (data_valid !== 1'b1) begin fails++; $display("FAIL glitch_valid got=%b want=1", data_valid); end
        e = exp_q.pop_front();
        tests++; if (rx_data !== e) begin fails++; $display("FAIL glitch_data got=%h want=%h", rx_data, e); end
        tests++; if (n_par + n_frm + n_to + n_ovr - e0 !== 0) begin
            fails++; $display("FAIL glitch_errors got=%0d want=0", n_par + n_frm + n_to + n_ovr - e0);
        end
    endtask

    task automatic test_reset_mid();
        send_bit(1'b0, 1'b0, 1'b0);
        send_bit(1'b1, 1'b0, 1'b0);
        send_bit(1'b0, 1'b0, 1'b0);
        tests++; if (busy !== 1'b1) begin fails++; $display("FAIL mid_busy_before got=%b want=1", busy); end
        rst = 1'b1;
        waitn(2);
        rst = 1'b0;
        sda = 1'b1;
        waitn(1);
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL mid_busy_after got=%b want=0", busy); end
        tests++; if (data_valid !== 1'b0) begin fails++; $display("FAIL mid_valid got=%b want=0", data_valid); end
        tests++; if (rx_data !== 8'h00) begin fails++; $display("FAIL mid_data got=%h want=00", rx_data); end
        waitn(50);
        tests++; if ({data_valid, busy} !== 2'b00) begin fails++; $display("FAIL mid_quiet got=%b want=00", {data_valid, busy}); end
    endtask

    initial begin
        test_reset();
        test_valid_ready();
        test_parity_frame();
        test_timeout();
        test_back_to_back();
        test_glitch();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
